// File: rtl/sprite_pkg.sv
// Shared types, colour-field positions and helpers for the sprite compositor.
// The sprite images are a fixed ROM built by image_pixel(), so every lane
// needs no external image file.
package sprite_pkg;

    typedef logic [8:0] rgb333_t;

    // RGB333 field positions; each field's LSB feeds the _1 pin
    localparam int unsigned RedLo = 6;
    localparam int unsigned GrnLo = 3;
    localparam int unsigned BluLo = 0;

    localparam rgb333_t RgbTransparent = 9'h1C7;
    localparam rgb333_t RgbBackground  = 9'h000;

    // Ceiling log2, usable in parameter expressions
    function automatic int unsigned sprite_clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((32'd1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Image set shared by every sprite slot:
    //   0: solid green          1: fully transparent
    //   2: blue top half, red bottom half
    //   3: white column 0, black elsewhere (shows horizontal flip)
    function automatic rgb333_t image_pixel(input int unsigned img, input int unsigned row,
                                            input int unsigned col, input int unsigned tile);
        rgb333_t pix;
        case (img)
            0:       pix = 9'h038;
            1:       pix = RgbTransparent;
            2:       pix = (row < tile / 2) ? 9'h007 : 9'h1C0;
            3:       pix = (col == 0) ? 9'h1FF : 9'h000;
            default: pix = RgbTransparent;
        endcase
        return pix;
    endfunction

endpackage

// File: rtl/sprite_lane.sv
// One sprite slot: hit test, image address (with optional mirror), a
// synchronous-read image ROM and the hit flag delayed to line up with its data.
module sprite_lane
    import sprite_pkg::*;
#(
    parameter int unsigned TILE_SIZE  = 32,
    parameter int unsigned NUM_IMAGES = 4,
    parameter int unsigned IMG_W      = 2
) (
    input  logic             i_Clk,
    input  logic             i_Rst,
    input  logic [9:0]       i_H_Counter,
    input  logic [9:0]       i_V_Counter,
    input  logic [9:0]       i_X,
    input  logic [9:0]       i_Y,
    input  logic [IMG_W-1:0] i_Img,
    input  logic             i_En,
    input  logic             i_Flip,
    output logic             o_Hit,
    output rgb333_t          o_Data
);

    localparam int unsigned TileW = sprite_clog2(TILE_SIZE);
    localparam int unsigned AddrW = sprite_clog2(NUM_IMAGES * TILE_SIZE * TILE_SIZE);

    logic [10:0]      w_h_ext, w_v_ext, w_x_ext, w_y_ext, w_x_end, w_y_end;
    logic             w_hit;
    logic [TileW-1:0] w_row, w_col_raw, w_col;
    logic [AddrW-1:0] w_addr;

    logic             r_hit_s1;
    logic [AddrW-1:0] r_addr_s1;
    logic             r_hit_s2;
    rgb333_t          r_data_s2;

    // 11-bit bounds so a sprite near column 1023 cannot wrap onto column 0
    assign w_h_ext = {1'b0, i_H_Counter};
    assign w_v_ext = {1'b0, i_V_Counter};
    assign w_x_ext = {1'b0, i_X};
    assign w_y_ext = {1'b0, i_Y};
    assign w_x_end = w_x_ext + 11'(TILE_SIZE);
    assign w_y_end = w_y_ext + 11'(TILE_SIZE);

    assign w_hit = i_En && (w_h_ext >= w_x_ext) && (w_h_ext < w_x_end)
                        && (w_v_ext >= w_y_ext) && (w_v_ext < w_y_end);

    // Only the low bits of the offsets matter once the hit test passes
    assign w_row     = i_V_Counter[TileW-1:0] - i_Y[TileW-1:0];
    assign w_col_raw = i_H_Counter[TileW-1:0] - i_X[TileW-1:0];
    // TILE_SIZE-1-col is a bitwise invert for a power-of-two tile
    assign w_col     = i_Flip ? ~w_col_raw : w_col_raw;
    assign w_addr    = AddrW'({i_Img, w_row, w_col});

    // S1: register hit flag and image address
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_hit_s1  <= 1'b0;
            r_addr_s1 <= '0;
        end else begin
            r_hit_s1  <= w_hit;
            r_addr_s1 <= w_addr;
        end
    end

    // S2: delay the hit flag to line up with the ROM read
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_hit_s2 <= 1'b0;
        end else begin
            r_hit_s2 <= r_hit_s1;
        end
    end

    // S2: synchronous ROM read; no reset so it maps onto block memory
    always_ff @(posedge i_Clk) begin
        r_data_s2 <= image_pixel(32'(r_addr_s1[AddrW-1:2*TileW]),
                                 32'(r_addr_s1[2*TileW-1:TileW]),
                                 32'(r_addr_s1[TileW-1:0]),
                                 TILE_SIZE);
    end

    assign o_Hit  = r_hit_s2;
    assign o_Data = r_data_s2;

endmodule

// File: rtl/sprite_compositor.sv
// Composes NUM_SPRITES sprite lanes over a background colour with fixed index
// priority and transparency keying, and reports per-frame player collisions.
// Counter-to-pin latency is three clocks.
module sprite_compositor
    import sprite_pkg::*;
#(
    parameter int unsigned NUM_SPRITES    = 8,
    parameter int unsigned TILE_SIZE      = 32,
    parameter int unsigned NUM_IMAGES     = 4,
    parameter int unsigned IMG_W          = 2,
    parameter int unsigned H_VISIBLE_AREA = 640,
    parameter int unsigned V_VISIBLE_AREA = 480,
    parameter rgb333_t     TRANSPARENT    = RgbTransparent,
    parameter rgb333_t     BG_COLOR       = RgbBackground
) (
    input  logic                         i_Clk,
    input  logic                         i_Rst,
    input  logic [9:0]                   i_H_Counter,
    input  logic [9:0]                   i_V_Counter,
    input  logic [10*NUM_SPRITES-1:0]    i_Sprite_X,
    input  logic [10*NUM_SPRITES-1:0]    i_Sprite_Y,
    input  logic [IMG_W*NUM_SPRITES-1:0] i_Sprite_Img,
    input  logic [NUM_SPRITES-1:0]       i_Sprite_En,
    input  logic [NUM_SPRITES-1:0]       i_Sprite_Flip,
    output logic                         o_VGA_Red_1,
    output logic                         o_VGA_Red_2,
    output logic                         o_VGA_Red_3,
    output logic                         o_VGA_Grn_1,
    output logic                         o_VGA_Grn_2,
    output logic                         o_VGA_Grn_3,
    output logic                         o_VGA_Blu_1,
    output logic                         o_VGA_Blu_2,
    output logic                         o_VGA_Blu_3,
    output logic                         o_Collision,
    output logic [NUM_SPRITES-1:0]       o_Collision_Mask
);

    localparam logic [9:0] HVisible = 10'(H_VISIBLE_AREA);
    localparam logic [9:0] VVisible = 10'(V_VISIBLE_AREA);

    logic [NUM_SPRITES-1:0] w_hit;
    rgb333_t                w_data [NUM_SPRITES];
    logic [NUM_SPRITES-1:0] w_opaque;
    logic [NUM_SPRITES-1:0] w_others;
    rgb333_t                w_color;

    logic                   r_vis_s1, r_vis_s2;
    logic                   r_frame_s1, r_frame_s2;
    rgb333_t                r_rgb;
    logic [NUM_SPRITES-1:0] r_sticky;
    logic [NUM_SPRITES-1:0] r_mask;
    logic                   r_coll;

    for (genvar k = 0; k < NUM_SPRITES; k++) begin : g_lane
        sprite_lane #(
            .TILE_SIZE  (TILE_SIZE),
            .NUM_IMAGES (NUM_IMAGES),
            .IMG_W      (IMG_W)
        ) u_lane (
            .i_Clk       (i_Clk),
            .i_Rst       (i_Rst),
            .i_H_Counter (i_H_Counter),
            .i_V_Counter (i_V_Counter),
            .i_X         (i_Sprite_X[10*k +: 10]),
            .i_Y         (i_Sprite_Y[10*k +: 10]),
            .i_Img       (i_Sprite_Img[IMG_W*k +: IMG_W]),
            .i_En        (i_Sprite_En[k]),
            .i_Flip      (i_Sprite_Flip[k]),
            .o_Hit       (w_hit[k]),
            .o_Data      (w_data[k])
        );
    end

    // S1/S2: visibility and frame-boundary flags travel alongside the lanes
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_vis_s1   <= 1'b0;
            r_vis_s2   <= 1'b0;
            r_frame_s1 <= 1'b0;
            r_frame_s2 <= 1'b0;
        end else begin
            r_vis_s1   <= (i_H_Counter < HVisible) && (i_V_Counter < VVisible);
            r_frame_s1 <= (i_V_Counter == VVisible) && (i_H_Counter == 10'd0);
            r_vis_s2   <= r_vis_s1;
            r_frame_s2 <= r_frame_s1;
        end
    end

    // Per-slot opaque flag: hit and not the colour key
    always_comb begin
        w_opaque = '0;
        for (int k = 0; k < int'(NUM_SPRITES); k++) begin
            w_opaque[k] = w_hit[k] && (w_data[k] != TRANSPARENT);
        end
    end

    // Priority select: walk from highest index down so the lowest opaque slot wins
    always_comb begin
        w_color = BG_COLOR;
        for (int k = int'(NUM_SPRITES) - 1; k >= 0; k--) begin
            if (w_opaque[k]) begin
                w_color = w_data[k];
            end
        end
    end

    // Other slots hit together with the player; slot 0 never collides with itself
    assign w_others = {w_opaque[NUM_SPRITES-1:1], 1'b0};

    // S3: output colour register, black outside the visible area
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_rgb <= '0;
        end else if (r_vis_s2) begin
            r_rgb <= w_color;
        end else begin
            r_rgb <= '0;
        end
    end

    // S3: accumulate collisions, publish and clear at the frame boundary pixel
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_sticky <= '0;
            r_mask   <= '0;
            r_coll   <= 1'b0;
        end else if (r_frame_s2) begin
            r_mask   <= r_sticky;
            r_coll   <= |r_sticky;
            r_sticky <= '0;
        end else if (r_vis_s2 && w_opaque[0]) begin
            r_sticky <= r_sticky | w_others;
        end
    end

    assign o_VGA_Red_1 = r_rgb[RedLo];
    assign o_VGA_Red_2 = r_rgb[RedLo+1];
    assign o_VGA_Red_3 = r_rgb[RedLo+2];
    assign o_VGA_Grn_1 = r_rgb[GrnLo];
    assign o_VGA_Grn_2 = r_rgb[GrnLo+1];
    assign o_VGA_Grn_3 = r_rgb[GrnLo+2];
    assign o_VGA_Blu_1 = r_rgb[BluLo];
    assign o_VGA_Blu_2 = r_rgb[BluLo+1];
    assign o_VGA_Blu_3 = r_rgb[BluLo+2];

    assign o_Collision      = r_coll;
    assign o_Collision_Mask = r_mask;

endmodule

// File: tb/tb_sprite_compositor.sv
// Bench for sprite_compositor: table of pixel vectors fed through a scoreboard
// queue, plus hand-written collision and reset sequences.
module tb_sprite_compositor;

    localparam int NS = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [9:0]      h_cnt, v_cnt;
    logic [10*NS-1:0] sp_x, sp_y;
    logic [2*NS-1:0] sp_img;
    logic [NS-1:0]   sp_en, sp_flip;
    logic            r1, r2, r3, g1, g2, g3, b1, b2, b3;
    logic            coll;
    logic [NS-1:0]   mask;
    logic [8:0]      rgb;

    logic [9:0] cx [NS];
    logic [9:0] cy [NS];
    logic [1:0] cimg [NS];

    int cyc = 0;
    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int         due;
        logic [8:0] exp;
        string      name;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        int         cfg;
        int         h;
        int         v;
        logic [8:0] exp;
    } vec_t;
    vec_t vecs[$];

    sprite_compositor dut (
        .i_Clk            (clk),
        .i_Rst            (rst),
        .i_H_Counter      (h_cnt),
        .i_V_Counter      (v_cnt),
        .i_Sprite_X       (sp_x),
        .i_Sprite_Y       (sp_y),
        .i_Sprite_Img     (sp_img),
        .i_Sprite_En      (sp_en),
        .i_Sprite_Flip    (sp_flip),
        .o_VGA_Red_1      (r1),
        .o_VGA_Red_2      (r2),
        .o_VGA_Red_3      (r3),
        .o_VGA_Grn_1      (g1),
        .o_VGA_Grn_2      (g2),
        .o_VGA_Grn_3      (g3),
        .o_VGA_Blu_1      (b1),
        .o_VGA_Blu_2      (b2),
        .o_VGA_Blu_3      (b3),
        .o_Collision      (coll),
        .o_Collision_Mask (mask)
    );

    assign rgb = {r3, r2, r1, g3, g2, g1, b3, b2, b1};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        sp_x   = '0;
        sp_y   = '0;
        sp_img = '0;
        for (int k = 0; k < NS; k++) begin
            sp_x[10*k +: 10] = cx[k];
            sp_y[10*k +: 10] = cy[k];
            sp_img[2*k +: 2] = cimg[k];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: compare each expected pixel when its due cycle arrives
    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            check(e.name, 32'(rgb), 32'(e.exp));
        end
    end

    task automatic set_slot(input int k, input int x, input int y, input int img,
                            input bit en, input bit flip);
        cx[k]      = 10'(x);
        cy[k]      = 10'(y);
        cimg[k]    = 2'(img);
        sp_en[k]   = en;
        sp_flip[k] = flip;
    endtask

    task automatic apply_cfg(input int cfg);
        for (int k = 0; k < NS; k++) set_slot(k, 0, 0, 0, 1'b0, 1'b0);
        case (cfg)
            0: set_slot(0, 100, 50, 0, 1'b1, 1'b0);
            1: begin
                set_slot(0, 200, 100, 1, 1'b1, 1'b0);
                set_slot(1, 200, 100, 2, 1'b1, 1'b0);
            end
            2: begin
                set_slot(0, 200, 100, 2, 1'b1, 1'b0);
                set_slot(1, 200, 100, 0, 1'b1, 1'b0);
            end
            3: set_slot(2, 300, 200, 3, 1'b1, 1'b1);
            4: set_slot(2, 300, 200, 3, 1'b1, 1'b0);
            5: set_slot(0, 1020, 0, 0, 1'b1, 1'b0);
            6: set_slot(0, 0, 0, 0, 1'b0, 1'b0);
            7: set_slot(0, 0, 0, 0, 1'b1, 1'b0);
            8: set_slot(0, 630, 470, 0, 1'b1, 1'b0);
            10: begin
                set_slot(0, 400, 300, 0, 1'b1, 1'b0);
                set_slot(3, 428, 300, 0, 1'b1, 1'b0);
            end
            11: begin
                set_slot(0, 400, 300, 0, 1'b1, 1'b0);
                set_slot(3, 500, 300, 0, 1'b1, 1'b0);
            end
            default: ;
        endcase
    endtask

    task automatic set_pix(input int cfg, input int h, input int v);
        apply_cfg(cfg);
        h_cnt = 10'(h);
        v_cnt = 10'(v);
    endtask

    // Drive one pixel just after a rising edge; its colour is due three edges later
    task automatic drive(input int cfg, input int h, input int v, input logic [8:0] exp,
                         input bit push, input string name);
        @(posedge clk);
        #1;
        set_pix(cfg, h, v);
        if (push) sb.push_back('{cyc + 3, exp, name});
    endtask

    // Frame-boundary pixel followed by three invisible pixels
    task automatic boundary(input int cfg);
        drive(cfg, 0, 480, 9'h000, 1'b1, "boundary_rgb");
        for (int i = 0; i < 3; i++) drive(cfg, 700, 10, 9'h000, 1'b1, "idle_rgb");
        @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain: %0d pixels still pending, expected 0", sb.size());
            sb.delete();
        end
    endtask

    function automatic void add(input int cfg, input int h, input int v, input logic [8:0] exp);
        vecs.push_back('{cfg, h, v, exp});
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        set_pix(6, 0, 0);

        add(0, 100, 50, 9'h038); add(0, 131, 50, 9'h038); add(0, 99, 50, 9'h000);
        add(0, 132, 50, 9'h000); add(0, 115, 81, 9'h038); add(0, 115, 82, 9'h000);
        add(0, 115, 49, 9'h000);
        add(1, 200, 100, 9'h007); add(1, 231, 100, 9'h007); add(1, 215, 116, 9'h1C0);
        add(2, 200, 116, 9'h1C0); add(2, 205, 100, 9'h007); add(2, 232, 100, 9'h000);
        add(3, 331, 200, 9'h1FF); add(3, 300, 200, 9'h000); add(3, 315, 210, 9'h000);
        add(4, 300, 200, 9'h1FF); add(4, 331, 200, 9'h000);
        add(5, 0, 0, 9'h000); add(5, 1, 0, 9'h000); add(5, 2, 0, 9'h000); add(5, 3, 0, 9'h000);
        add(6, 0, 0, 9'h000); add(6, 3, 0, 9'h000);
        add(7, 0, 0, 9'h038); add(7, 3, 0, 9'h038);
        add(8, 639, 470, 9'h038); add(8, 640, 470, 9'h000); add(8, 635, 479, 9'h038);
        add(8, 635, 480, 9'h000); add(8, 700, 475, 9'h000);

        #12;
        check("reset_rgb", 32'(rgb), 32'h0);
        check("reset_coll", 32'(coll), 32'h0);
        check("reset_mask", 32'(mask), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].cfg, vecs[i].h, vecs[i].v, vecs[i].exp, 1'b1,
                  $sformatf("vec%0d", i));
        end
        drain();

        // The priority vectors with slots 0 and 1 both opaque count as a collision
        boundary(10);
        check("table_frame_coll", 32'(coll), 32'h1);
        check("table_frame_mask", 32'(mask), 32'h02);

        // Frame N: four opaque overlap pixels with slot 3
        for (int h = 427; h <= 431; h++) drive(10, h, 300, 9'h038, 1'b1, "frameN_rgb");
        @(negedge clk);
        check("held_coll", 32'(coll), 32'h1);
        check("held_mask", 32'(mask), 32'h02);
        boundary(10);
        check("frameN_coll", 32'(coll), 32'h1);
        check("frameN_mask", 32'(mask), 32'h08);

        // Frame N+1: no overlap
        for (int h = 427; h <= 431; h++) drive(11, h, 300, 9'h038, 1'b1, "frameN1_rgb");
        boundary(11);
        check("frameN1_coll", 32'(coll), 32'h0);
        check("frameN1_mask", 32'(mask), 32'h00);

        // Reset mid-line with a collision pending in the sticky mask
        for (int h = 428; h <= 431; h++) drive(10, h, 300, 9'h038, 1'b1, "prereset_rgb");
        for (int i = 0; i < 3; i++) drive(10, 410, 300, 9'h038, 1'b0, "");
        @(negedge clk);
        check("prereset_pin", 32'(rgb), 32'h038);
        #1;
        rst = 1'b1;
        #1;
        check("midreset_rgb", 32'(rgb), 32'h0);
        check("midreset_coll", 32'(coll), 32'h0);
        check("midreset_mask", 32'(mask), 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        set_pix(10, 410, 300);
        @(negedge clk);
        @(negedge clk);
        check("release_cycle1", 32'(rgb), 32'h0);
        @(negedge clk);
        check("release_cycle2", 32'(rgb), 32'h0);
        @(negedge clk);
        check("release_cycle3", 32'(rgb), 32'h038);
        check("release_coll", 32'(coll), 32'h0);
        boundary(10);
        check("postreset_coll", 32'(coll), 32'h0);
        check("postreset_mask", 32'(mask), 32'h00);
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
